// File: rtl/video_timing_pkg.sv
// Shared types and timing constants for the DVI raster timing generator.
package video_timing_pkg;

   typedef enum logic {
      SYNC_WAIT = 1'b0,
      RUN       = 1'b1
   } vt_state_e;

   typedef struct packed {
      int unsigned h_active;
      int unsigned h_fp;
      int unsigned h_sync;
      int unsigned h_bp;
      int unsigned v_active;
      int unsigned v_fp;
      int unsigned v_sync;
      int unsigned v_bp;
   } timing_t;

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock
   localparam timing_t TIMING_640X480_60 = '{
      h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
      v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
   };

   function automatic int unsigned h_total(timing_t t);
      return t.h_active + t.h_fp + t.h_sync + t.h_bp;
   endfunction

   function automatic int unsigned v_total(timing_t t);
      return t.v_active + t.v_fp + t.v_sync + t.v_bp;
   endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Valid/ready pixel stream from the framebuffer reader / CDC FIFO into the timing generator.
interface video_timing_gen_if;
   logic        pixel_valid;
   logic        pixel_ready;
   logic        pixel_sof;
   logic [23:0] pixel_data;

   modport master (
      output pixel_valid,
      output pixel_sof,
      output pixel_data,
      input  pixel_ready
   );

   modport slave (
      input  pixel_valid,
      input  pixel_sof,
      input  pixel_data,
      output pixel_ready
   );
endinterface

// File: rtl/video_sync_counter.sv
// Free-running horizontal/vertical raster counters with sync-window and active-area decode.
module video_sync_counter
   import video_timing_pkg::*;
#(
   parameter timing_t     TIMING = TIMING_640X480_60,
   parameter int unsigned H_W    = 10,
   parameter int unsigned V_W    = 10
) (
   input  logic           clock,
   input  logic           reset,
   output logic [H_W-1:0] h_cnt,
   output logic [V_W-1:0] v_cnt,
   output logic           h_last,
   output logic           v_last,
   output logic           active,
   output logic           hs_raw,
   output logic           vs_raw
);

   localparam int unsigned H_TOTAL  = h_total(TIMING);
   localparam int unsigned V_TOTAL  = v_total(TIMING);
   localparam int unsigned HS_START = TIMING.h_active + TIMING.h_fp;
   localparam int unsigned HS_END   = HS_START + TIMING.h_sync;
   localparam int unsigned VS_START = TIMING.v_active + TIMING.v_fp;
   localparam int unsigned VS_END   = VS_START + TIMING.v_sync;

   // Decode in 32 bits so window ends equal to the total never alias
   logic [31:0] h_ext;
   logic [31:0] v_ext;

   assign h_ext  = 32'(h_cnt);
   assign v_ext  = 32'(v_cnt);
   assign h_last = (h_ext == H_TOTAL - 1);
   assign v_last = (v_ext == V_TOTAL - 1);
   assign active = (h_ext < TIMING.h_active) && (v_ext < TIMING.v_active);
   assign hs_raw = (h_ext >= HS_START) && (h_ext < HS_END);
   assign vs_raw = (v_ext >= VS_START) && (v_ext < VS_END);

   // Advance the raster position; the line counter steps on each horizontal wrap
   always_ff @(posedge clock) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
      end else begin
         h_cnt <= h_cnt + H_W'(1);
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// DVI raster timing generator: aligns an incoming pixel stream to the raster and
// drives registered vs/hs/de/rgb, recovering from underflow and misalignment.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   SYNC_WAIT | black output; drain non-SOF pixels, hold a SOF pixel at head
//   RUN       | locked; one pixel consumed per active cycle
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE         = TIMING_640X480_60.h_active,
   parameter int unsigned H_FP             = TIMING_640X480_60.h_fp,
   parameter int unsigned H_SYNC           = TIMING_640X480_60.h_sync,
   parameter int unsigned H_BP             = TIMING_640X480_60.h_bp,
   parameter int unsigned V_ACTIVE         = TIMING_640X480_60.v_active,
   parameter int unsigned V_FP             = TIMING_640X480_60.v_fp,
   parameter int unsigned V_SYNC           = TIMING_640X480_60.v_sync,
   parameter int unsigned V_BP             = TIMING_640X480_60.v_bp,
   parameter bit          SYNC_ACTIVE_HIGH = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   video_timing_gen_if.slave pix,
   output logic              rgb_vs,
   output logic              rgb_hs,
   output logic              rgb_de,
   output logic [7:0]        rgb_r,
   output logic [7:0]        rgb_g,
   output logic [7:0]        rgb_b,
   output logic              frame_start,
   output logic              locked,
   output logic              underflow,
   input  logic              clear_underflow
);

   localparam timing_t TIMING = '{
      h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
      v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
   };
   localparam int unsigned H_W = $clog2(h_total(TIMING));
   localparam int unsigned V_W = $clog2(v_total(TIMING));

   logic [H_W-1:0] h_cnt;
   logic [V_W-1:0] v_cnt;
   logic           h_last;
   logic           v_last;
   logic           active;
   logic           hs_raw;
   logic           vs_raw;

   vt_state_e      state_q;
   vt_state_e      state_d;
   logic           first_pix;
   logic           sof_early;
   logic           misalign;
   logic           ready_c;
   logic           take_c;
   logic           stream_err;

   video_sync_counter #(
      .TIMING (TIMING),
      .H_W    (H_W),
      .V_W    (V_W)
   ) u_sync_counter (
      .clock  (clock),
      .reset  (reset),
      .h_cnt  (h_cnt),
      .v_cnt  (v_cnt),
      .h_last (h_last),
      .v_last (v_last),
      .active (active),
      .hs_raw (hs_raw),
      .vs_raw (vs_raw)
   );

   assign first_pix = (h_cnt == '0) && (v_cnt == '0);
   // A SOF showing up anywhere but the first pixel is left at the head for relock
   assign sof_early = pix.pixel_valid && pix.pixel_sof && !first_pix;
   assign misalign  = active && (!pix.pixel_valid || (pix.pixel_sof != first_pix));

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= SYNC_WAIT;
      else       state_q <= state_d;
   end

   // Next state: lock on the last raster cycle with a SOF waiting, drop on any stream error
   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC_WAIT: if (h_last && v_last && pix.pixel_valid && pix.pixel_sof) state_d = RUN;
         RUN:       if (misalign) state_d = SYNC_WAIT;
         default:   state_d = SYNC_WAIT;
      endcase
   end

   // Handshake and error decode per state
   always_comb begin
      ready_c    = 1'b0;
      stream_err = 1'b0;
      case (state_q)
         SYNC_WAIT: ready_c = pix.pixel_valid && !pix.pixel_sof;
         RUN: begin
            ready_c    = active && !sof_early;
            stream_err = misalign;
         end
         default: ready_c = 1'b0;
      endcase
      take_c = (state_q == RUN) && ready_c && pix.pixel_valid;
   end

   assign pix.pixel_ready = ready_c;
   assign locked          = (state_q == RUN);

   // Output register: timing always runs, pixels only when consumed while locked
   always_ff @(posedge clock) begin
      if (reset) begin
         rgb_de               <= 1'b0;
         rgb_hs               <= ~SYNC_ACTIVE_HIGH;
         rgb_vs               <= ~SYNC_ACTIVE_HIGH;
         {rgb_r, rgb_g, rgb_b} <= '0;
         frame_start          <= 1'b0;
      end else begin
         rgb_de               <= active;
         rgb_hs               <= hs_raw ~^ SYNC_ACTIVE_HIGH;
         rgb_vs               <= vs_raw ~^ SYNC_ACTIVE_HIGH;
         {rgb_r, rgb_g, rgb_b} <= take_c ? pix.pixel_data : 24'h0;
         frame_start          <= (state_q == RUN) && first_pix;
      end
   end

   // Sticky underflow; a new error wins over a simultaneous clear
   always_ff @(posedge clock) begin
      if (reset)                underflow <= 1'b0;
      else if (stream_err)      underflow <= 1'b1;
      else if (clear_underflow) underflow <= 1'b0;
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a reduced 14x7 raster.
module tb_video_timing_gen;

   localparam int HA = 8, HF = 2, HS = 2, HB = 2;
   localparam int VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam bit SAH = 1'b1;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       clear_underflow = 1'b0;
   logic       rgb_vs, rgb_hs, rgb_de, frame_start, locked, underflow;
   logic [7:0] rgb_r, rgb_g, rgb_b;

   video_timing_gen_if pix_if ();

   video_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .SYNC_ACTIVE_HIGH (SAH)
   ) u_dut (
      .clock           (clock),
      .reset           (reset),
      .pix             (pix_if),
      .rgb_vs          (rgb_vs),
      .rgb_hs          (rgb_hs),
      .rgb_de          (rgb_de),
      .rgb_r           (rgb_r),
      .rgb_g           (rgb_g),
      .rgb_b           (rgb_b),
      .frame_start     (frame_start),
      .locked          (locked),
      .underflow       (underflow),
      .clear_underflow (clear_underflow)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        sof;
      logic [23:0] data;
   } pix_t;

   pix_t src_q[$];
   int   n_vec = 0, n_miss = 0;
   int   m_t = 0;
   bit   m_locked = 0, m_und = 0;
   bit   gap = 0, rst = 1, clr = 0;
   int   n_de, n_hs, n_vs, n_drain;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   function automatic int cur_h();
      return m_t % HT;
   endfunction

   function automatic int cur_v();
      return (m_t / HT) % VT;
   endfunction

   task automatic push_frame(int unsigned base, int len);
      for (int i = 0; i < len; i++) src_q.push_back({(i == 0), 24'(base + i)});
   endtask

   // One pixel clock: drive, predict from raster position and lock status, check
   task automatic cycle();
      int h, v;
      bit act, first, pv, psof, rdy, cons, err, e_lock, e_und, e_hs, e_vs;
      logic [23:0] pdata, e_rgb;
      h     = cur_h();
      v     = cur_v();
      act   = (h < HA) && (v < VA);
      first = (h == 0) && (v == 0);
      pv    = (src_q.size() > 0) && !gap && !rst;
      psof  = (src_q.size() > 0) ? src_q[0].sof : 1'b0;
      pdata = (src_q.size() > 0) ? src_q[0].data : 24'h0;
      reset = rst;
      clear_underflow    = clr;
      pix_if.pixel_valid = pv;
      pix_if.pixel_sof   = psof;
      pix_if.pixel_data  = pdata;

      rdy    = m_locked ? (act && !(pv && psof && !first)) : (pv && !psof);
      cons   = pv && rdy;
      err    = m_locked && act && (!pv || (psof != first));
      e_lock = m_locked ? !err : ((h == HT - 1) && (v == VT - 1) && pv && psof);
      e_und  = err ? 1'b1 : (clr ? 1'b0 : m_und);
      e_rgb  = (m_locked && cons) ? pdata : 24'h0;
      e_hs   = ((h >= HA + HF) && (h < HA + HF + HS)) ~^ SAH;
      e_vs   = ((v >= VA + VF) && (v < VA + VF + VS)) ~^ SAH;

      #1;
      if (!rst) begin
         chk("pixel_ready", 32'(pix_if.pixel_ready), 32'(rdy));
         if (pv && pix_if.pixel_ready && !m_locked) n_drain++;
      end
      @(posedge clock);
      #1;
      if (rst) begin
         chk("rst_de", 32'(rgb_de), 32'(0));
         chk("rst_hs", 32'(rgb_hs), 32'(!SAH));
         chk("rst_vs", 32'(rgb_vs), 32'(!SAH));
         chk("rst_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'(0));
         chk("rst_frame_start", 32'(frame_start), 32'(0));
         chk("rst_locked", 32'(locked), 32'(0));
         chk("rst_underflow", 32'(underflow), 32'(0));
         m_t = 0;
         m_locked = 0;
         m_und = 0;
      end else begin
         chk("de", 32'(rgb_de), 32'(act));
         chk("hs", 32'(rgb_hs), 32'(e_hs));
         chk("vs", 32'(rgb_vs), 32'(e_vs));
         chk("rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'(e_rgb));
         chk("frame_start", 32'(frame_start), 32'(m_locked && first));
         chk("locked", 32'(locked), 32'(e_lock));
         chk("underflow", 32'(underflow), 32'(e_und));
         n_de += int'(rgb_de);
         n_hs += int'(rgb_hs);
         n_vs += int'(rgb_vs);
         if (cons) void'(src_q.pop_front());
         m_t++;
         m_locked = e_lock;
         m_und = e_und;
      end
      @(negedge clock);
   endtask

   task automatic do_reset();
      rst = 1;
      cycle();
      rst = 0;
   endtask

   initial begin
      bit done, cdone;
      pix_if.pixel_valid = 1'b0;
      pix_if.pixel_sof   = 1'b0;
      pix_if.pixel_data  = 24'h0;
      @(negedge clock);
      rst = 1;
      repeat (3) cycle();
      rst = 0;

      // Timing only, no source
      n_de = 0; n_hs = 0; n_vs = 0;
      repeat (2 * FRAME) cycle();
      chk("de_count_2frames", 32'(n_de), 32'(2 * VA * HA));
      chk("hs_count_2frames", 32'(n_hs), 32'(2 * VT * HS));
      chk("vs_count_2frames", 32'(n_vs), 32'(2 * VS * HT));

      // Lock on a counting frame, then two random frames
      push_frame(1, HA * VA);
      push_frame($urandom_range(0, 24'hFFFFFF), HA * VA);
      push_frame($urandom_range(0, 24'hFFFFFF), HA * VA);
      repeat (4 * FRAME) cycle();

      // Drain five stray pixels before the SOF frame
      do_reset();
      for (int i = 0; i < 5; i++) src_q.push_back({1'b0, 24'($urandom)});
      push_frame($urandom_range(0, 24'hFFFFFF), HA * VA);
      push_frame($urandom_range(0, 24'hFFFFFF), HA * VA);
      n_drain = 0;
      repeat (3 * FRAME) cycle();
      chk("drain_count", 32'(n_drain), 32'(5));

      // One-cycle underflow at line 2 pixel 3, relock, then clear
      for (int i = 0; i < 3; i++) push_frame($urandom_range(0, 24'hFFFFFF), HA * VA);
      done = 0;
      cdone = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         gap = m_locked && !done && (cur_h() == 3) && (cur_v() == 2);
         if (gap) done = 1;
         clr = m_locked && done && !cdone && (cur_h() == 6) && (cur_v() == 3);
         if (clr) cdone = 1;
         cycle();
      end
      gap = 0;
      clr = 0;
      chk("underflow_cleared_seen", 32'(cdone), 32'(1));

      // Early SOF at line 1 pixel 0
      push_frame($urandom_range(0, 24'hFFFFFF), HA * VA);
      push_frame($urandom_range(0, 24'hFFFFFF), HA);
      push_frame($urandom_range(0, 24'hFFFFFF), HA * VA);
      repeat (3 * FRAME) cycle();

      // Reset mid-line at h=4, v=2 while locked
      push_frame($urandom_range(0, 24'hFFFFFF), HA * VA);
      push_frame($urandom_range(0, 24'hFFFFFF), HA * VA);
      done = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         rst = m_locked && !done && (cur_h() == 4) && (cur_v() == 2);
         if (rst) done = 1;
         cycle();
      end
      rst = 0;
      chk("midline_reset_seen", 32'(done), 32'(1));

      // Random traffic: short/long frames, gaps, clears, rare resets
      do_reset();
      src_q.delete();
      for (int i = 0; i < 20 * FRAME; i++) begin
         if (src_q.size() < 40)
            push_frame($urandom_range(0, 24'hFFFFFF),
                       ($urandom_range(0, 3) != 0) ? HA * VA : $urandom_range(1, 40));
         gap = ($urandom_range(0, 99) == 0);
         clr = ($urandom_range(0, 29) == 0);
         rst = ($urandom_range(0, 999) == 0);
         cycle();
      end
      gap = 0;
      clr = 0;
      rst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
